// File: rtl/ft2232h_tx_arb_if.sv
// Purpose : bundles the requester streams and the FT2232H transmit pins of
//           ft2232h_tx_arb so they travel as one port.
// Signals : req_valid_i/req_data_i/req_last_i/req_ready_o - requester streams
//           (requester k owns req_data_i[8k+7:8k]);
//           data_o/wr_o/txe_i - FT2232H data bus, WR# and TXE#;
//           grant_o/busy_o/tx_count_o - arbiter status.
// Modports: master = arbiter side, slave = requester/pin side.
interface ft2232h_tx_arb_if #(
    parameter int unsigned NREQ = 4
);
    logic [NREQ-1:0]   req_valid_i;
    logic [8*NREQ-1:0] req_data_i;
    logic [NREQ-1:0]   req_last_i;
    logic [NREQ-1:0]   req_ready_o;
    logic [7:0]        data_o;
    logic              wr_o;
    logic              txe_i;
    logic [NREQ-1:0]   grant_o;
    logic              busy_o;
    logic [31:0]       tx_count_o;

    modport master (
        input  req_valid_i, req_data_i, req_last_i, txe_i,
        output req_ready_o, data_o, wr_o, grant_o, busy_o, tx_count_o
    );

    modport slave (
        output req_valid_i, req_data_i, req_last_i, txe_i,
        input  req_ready_o, data_o, wr_o, grant_o, busy_o, tx_count_o
    );
endinterface

// File: rtl/ft2232h_tx_arb.sv
// Purpose : round-robin arbiter/sequencer sharing the FT2232H synchronous-FIFO
//           transmit port among NREQ byte-stream requesters. One grant covers a
//           packet or at most BURST_MAX bytes.
// Ports   : clkout_i - FT2232H CLKOUT (60 MHz), rising edge
//           rst_n_i  - asynchronous active-low reset
//           bus      - ft2232h_tx_arb_if.master (requester streams, pins, status)
// Config  : define FT_TX_HEADER_EN to prefix every grant with tag byte 0xA0|idx.
module ft2232h_tx_arb #(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned BURST_MAX = 16
) (
    input  logic             clkout_i,
    input  logic             rst_n_i,
    ft2232h_tx_arb_if.master bus
);

    localparam int unsigned IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned BCW  = 8;
    localparam int unsigned CNTW = 32;

`ifdef FT_TX_HEADER_EN
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_DATA = 2'd2
    } state_e;
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd2
    } state_e;
`endif

    state_e            state_q, state_d;
    logic              out_v_q, out_v_d;
    logic [7:0]        data_q, data_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [IDXW-1:0]   last_q, last_d;
    logic [BCW-1:0]    burst_q, burst_d;
    logic [CNTW-1:0]   tx_count_q, tx_count_d;
    logic              busy_q, busy_d;

    logic              accept;
    logic              load_ok;
    logic              load;
    logic [7:0]        load_byte;
    logic              pick_found;
    logic [IDXW-1:0]   pick_idx;
    logic              cur_valid;
    logic              cur_last;
    logic [7:0]        cur_data;
    logic [NREQ-1:0]   ready_c;

    // Output stage handshake: a byte leaves on an edge with WR# and TXE# low.
    assign accept  = out_v_q & ~bus.txe_i;
    assign load_ok = ~out_v_q | accept;

    // First valid requester searching upward from last_grant+1.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            if (!pick_found && bus.req_valid_i[IDXW'((32'(last_q) + i) % NREQ)]) begin
                pick_found = 1'b1;
                pick_idx   = IDXW'((32'(last_q) + i) % NREQ);
            end
        end
    end

    // Stream of the current owner.
    always_comb begin
        cur_valid = 1'b0;
        cur_last  = 1'b0;
        cur_data  = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (idx_q == IDXW'(k)) begin
                cur_valid = bus.req_valid_i[k];
                cur_last  = bus.req_last_i[k];
                cur_data  = bus.req_data_i[8*k +: 8];
            end
        end
    end

    // Arbitration / sequencing next state.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        idx_d     = idx_q;
        last_d    = last_q;
        burst_d   = burst_q;
        load      = 1'b0;
        load_byte = '0;
        ready_c   = '0;
        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    grant_d = NREQ'(1) << pick_idx;
                    idx_d   = pick_idx;
                    burst_d = '0;
`ifdef FT_TX_HEADER_EN
                    state_d = S_HDR;
`else
                    state_d = S_DATA;
`endif
                end
            end
`ifdef FT_TX_HEADER_EN
            S_HDR: begin
                if (load_ok) begin
                    load      = 1'b1;
                    load_byte = {4'hA, 4'(idx_q)};
                    state_d   = S_DATA;
                end
            end
`endif
            S_DATA: begin
                ready_c[idx_q] = load_ok;
                if (cur_valid && load_ok) begin
                    load      = 1'b1;
                    load_byte = cur_data;
                    burst_d   = burst_q + BCW'(1);
                    // Truncation leaves the rest of the packet for the next grant.
                    if (cur_last || ((burst_q + BCW'(1)) == BCW'(BURST_MAX))) begin
                        state_d = S_IDLE;
                        last_d  = idx_q;
                        grant_d = '0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Holding register and counters; a load on an accepting edge replaces the byte.
    always_comb begin
        out_v_d = out_v_q;
        data_d  = data_q;
        if (accept) begin
            out_v_d = 1'b0;
        end
        if (load) begin
            out_v_d = 1'b1;
            data_d  = load_byte;
        end
        tx_count_d = tx_count_q + CNTW'(accept);
        busy_d     = (state_d != S_IDLE) | out_v_d;
    end

    always_ff @(posedge clkout_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= S_IDLE;
            out_v_q    <= 1'b0;
            data_q     <= '0;
            grant_q    <= '0;
            idx_q      <= '0;
            last_q     <= IDXW'(NREQ - 1);
            burst_q    <= '0;
            tx_count_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            out_v_q    <= out_v_d;
            data_q     <= data_d;
            grant_q    <= grant_d;
            idx_q      <= idx_d;
            last_q     <= last_d;
            burst_q    <= burst_d;
            tx_count_q <= tx_count_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.data_o      = data_q;
    assign bus.wr_o        = ~out_v_q;
    assign bus.grant_o     = grant_q;
    assign bus.busy_o      = busy_q;
    assign bus.tx_count_o  = tx_count_q;
    assign bus.req_ready_o = ready_c;

endmodule

// File: tb/tb_ft2232h_tx_arb.sv
// Purpose : self-checking bench for ft2232h_tx_arb (NREQ=4, BURST_MAX=4).
//           Works with and without FT_TX_HEADER_EN defined.
module tb_ft2232h_tx_arb;

    localparam int unsigned NREQ = 4;
    localparam int unsigned BMAX = 4;
`ifdef FT_TX_HEADER_EN
    localparam int unsigned NHDR = 1;
`else
    localparam int unsigned NHDR = 0;
`endif

    logic clk = 1'b0;
    logic rst_n;

    ft2232h_tx_arb_if #(.NREQ(NREQ)) ifc ();

    ft2232h_tx_arb #(.NREQ(NREQ), .BURST_MAX(BMAX)) dut (
        .clkout_i (clk),
        .rst_n_i  (rst_n),
        .bus      (ifc.master)
    );

    always #5 clk = ~clk;

    logic [8:0]      srcq [NREQ][$];
    logic [7:0]      expq [$];
    int unsigned     acc_cyc [$];
    logic [NREQ-1:0] grant_log [$];
    int unsigned     cyc = 0;
    int unsigned     n_hs = 0;
    int              passed = 0;
    int              failed = 0;
    int              total = 0;
    logic [31:0]     exp_cnt = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit src_pending();
        bit p = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (srcq[k].size() != 0) p = 1'b1;
        end
        return p;
    endfunction

    // Queue a packet on requester k and the bytes the bus must show for it.
    task automatic send_pkt(input int unsigned k, input int unsigned n,
                            input logic [7:0] base, input logic [7:0] step);
        int unsigned b = 0;
        logic [7:0]  d;
        for (int unsigned i = 0; i < n; i++) begin
            d = base + 8'(i) * step;
            srcq[k].push_back({(i == n - 1), d});
            if (b == 0 && NHDR == 1) begin
                expq.push_back(8'hA0 | 8'(k));
                exp_cnt = exp_cnt + 32'd1;
            end
            expq.push_back(d);
            exp_cnt = exp_cnt + 32'd1;
            b = (b + 1 == BMAX) ? 0 : b + 1;
        end
    endtask

    task automatic drain(input string tag);
        int unsigned c = 0;
        while ((expq.size() != 0 || ifc.busy_o || src_pending()) && c < 400) begin
            @(negedge clk);
            c++;
        end
        repeat (2) @(negedge clk);
        check({tag, "_drained"}, 32'(c < 400), 32'd1);
    endtask

    // Requester models and bus scoreboard.
    initial begin
        logic [NREQ-1:0] hs;
        logic [NREQ-1:0] prev_grant;
        logic            acc;
        logic [7:0]      abyte;
        logic [8:0]      e;
        prev_grant      = '0;
        ifc.req_valid_i = '0;
        ifc.req_last_i  = '0;
        ifc.req_data_i  = '0;
        forever begin
            @(posedge clk);
            cyc++;
            hs    = '0;
            acc   = 1'b0;
            abyte = '0;
            if (rst_n) begin
                hs    = ifc.req_valid_i & ifc.req_ready_o;
                acc   = !ifc.wr_o && !ifc.txe_i;
                abyte = ifc.data_o;
                check("ready_owner", 32'(ifc.req_ready_o & ~ifc.grant_o), 32'd0);
                if (ifc.grant_o != '0 && prev_grant == '0) grant_log.push_back(ifc.grant_o);
                prev_grant = ifc.grant_o;
            end else begin
                prev_grant = '0;
            end
            #1;
            for (int k = 0; k < NREQ; k++) begin
                if (hs[k] && srcq[k].size() != 0) begin
                    void'(srcq[k].pop_front());
                    n_hs++;
                end
            end
            if (acc) begin
                if (expq.size() == 0) begin
                    check("spurious_byte", 32'(expq.size()), 32'd1);
                end else begin
                    check("bus_byte", 32'(abyte), 32'(expq.pop_front()));
                    acc_cyc.push_back(cyc);
                end
            end
            for (int k = 0; k < NREQ; k++) begin
                if (srcq[k].size() != 0) begin
                    e = srcq[k][0];
                    ifc.req_valid_i[k]       = 1'b1;
                    ifc.req_last_i[k]        = e[8];
                    ifc.req_data_i[8*k +: 8] = e[7:0];
                end else begin
                    ifc.req_valid_i[k]       = 1'b0;
                    ifc.req_last_i[k]        = 1'b0;
                    ifc.req_data_i[8*k +: 8] = 8'h00;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned     c;
        int unsigned     hs0;
        int unsigned     hs1;
        logic [7:0]      held;
        logic [31:0]     cnt0;
        logic [NREQ-1:0] g_exp [5];

        rst_n     = 1'b0;
        ifc.txe_i = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_wr",    32'(ifc.wr_o),        32'd1);
        check("rst_data",  32'(ifc.data_o),      32'd0);
        check("rst_grant", 32'(ifc.grant_o),     32'd0);
        check("rst_ready", 32'(ifc.req_ready_o), 32'd0);
        check("rst_busy",  32'(ifc.busy_o),      32'd0);
        check("rst_count", ifc.tx_count_o,       32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single 3-byte packet from requester 0.
        acc_cyc.delete();
        send_pkt(0, 3, 8'h11, 8'h11);
        drain("t1");
        check("t1_count",   ifc.tx_count_o,          32'(3 + NHDR));
        check("t1_grant",   32'(ifc.grant_o),        32'd0);
        check("t1_accepts", 32'(acc_cyc.size()),     32'(3 + NHDR));
        if (acc_cyc.size() != 0)
            check("t1_back_to_back", 32'(acc_cyc[acc_cyc.size() - 1] - acc_cyc[0]), 32'(2 + NHDR));

        // All requesters contending with 1-byte packets; requester 0 was served last.
        grant_log.delete();
        send_pkt(1, 1, 8'h41, 8'h00);
        send_pkt(2, 1, 8'h42, 8'h00);
        send_pkt(3, 1, 8'h43, 8'h00);
        send_pkt(0, 1, 8'h40, 8'h00);
        send_pkt(1, 1, 8'h51, 8'h00);
        drain("t2");
        g_exp = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        check("t2_grants", 32'(grant_log.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < grant_log.size())
                check($sformatf("t2_grant%0d", i), 32'(grant_log[i]), 32'(g_exp[i]));
        end
        check("t2_count", ifc.tx_count_o, exp_cnt);

        // TXE# throttling mid-burst.
        hs0 = n_hs;
        send_pkt(2, 6, 8'h60, 8'h01);
        c = 0;
        while (n_hs - hs0 < 2 && c < 50) begin
            @(negedge clk);
            c++;
        end
        check("t3_started", 32'(c < 50), 32'd1);
        ifc.txe_i = 1'b1;
        held = ifc.data_o;
        hs1  = n_hs;
        check("t3_held", 32'(held), 32'h61);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t3_data_stable", 32'(ifc.data_o),      32'(held));
            check("t3_wr_low",      32'(ifc.wr_o),        32'd0);
            check("t3_ready_low",   32'(ifc.req_ready_o), 32'd0);
        end
        check("t3_no_take", 32'(n_hs - hs1), 32'd0);
        ifc.txe_i = 1'b0;
        drain("t3");
        check("t3_count", ifc.tx_count_o, exp_cnt);

        // 10-byte packet truncated into 4/4/2 bursts.
        cnt0 = ifc.tx_count_o;
        grant_log.delete();
        send_pkt(0, 10, 8'h80, 8'h01);
        drain("t4");
        check("t4_count", ifc.tx_count_o - cnt0, 32'(10 + 3 * NHDR));
        check("t4_bursts", 32'(grant_log.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < grant_log.size())
                check($sformatf("t4_grant%0d", i), 32'(grant_log[i]), 32'd1);
        end

        // Reset in the middle of requester 1's burst.
        hs0 = n_hs;
        send_pkt(1, 8, 8'hB0, 8'h01);
        c = 0;
        while (n_hs - hs0 < 2 && c < 50) begin
            @(negedge clk);
            c++;
        end
        check("t5_started", 32'(c < 50), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t5_wr",    32'(ifc.wr_o),        32'd1);
        check("t5_data",  32'(ifc.data_o),      32'd0);
        check("t5_grant", 32'(ifc.grant_o),     32'd0);
        check("t5_ready", 32'(ifc.req_ready_o), 32'd0);
        check("t5_busy",  32'(ifc.busy_o),      32'd0);
        check("t5_count", ifc.tx_count_o,       32'd0);
        for (int k = 0; k < NREQ; k++) srcq[k].delete();
        expq.delete();
        exp_cnt = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        grant_log.delete();
        send_pkt(0, 1, 8'hC0, 8'h00);
        send_pkt(1, 1, 8'hC1, 8'h00);
        drain("t5");
        check("t5_grants", 32'(grant_log.size()), 32'd2);
        if (grant_log.size() != 0)
            check("t5_first_grant", 32'(grant_log[0]), 32'd1);
        check("t5_count_after", ifc.tx_count_o, exp_cnt);

        // Byte counter wrap.
        @(negedge clk);
        force dut.tx_count_q = 32'hFFFF_FFFE;
        @(negedge clk);
        release dut.tx_count_q;
        exp_cnt = 32'hFFFF_FFFE;
        check("t6_preload", ifc.tx_count_o, 32'hFFFF_FFFE);
        send_pkt(3, 3 - NHDR, 8'hD0, 8'h01);
        drain("t6");
        check("t6_wrap", ifc.tx_count_o, 32'h0000_0001);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ft2232h_tx_arb.md
# ft2232h_tx_arb

- Round-robin arbiter and sequencer that shares the FT2232H synchronous-FIFO transmit port among NREQ byte-stream requesters.
- Drives the FT2232H data bus and active-low write strobe, and honours the active-low TXE flow control.
- Grants the port to one requester per packet or burst, and optionally prefixes each burst with a channel tag byte.
- Sits between the on-FPGA packet sources and the FT2232H pins, in the CLKOUT (60 MHz) domain.

## Interface
Parameters:
- NREQ, 4: number of requesters, 2..16.
- BURST_MAX, 16: maximum payload bytes per grant, 1..255.

Ports:
- clkout_i  in  1  FT2232H CLKOUT; the single clock, rising edge.
- rst_n_i  in  1  asynchronous, active-low reset.
- req_valid_i  in  NREQ  per-requester byte valid.
- req_data_i  in  8*NREQ  per-requester byte; requester k uses bits [8k+7:8k].
- req_last_i  in  NREQ  per-requester end-of-packet flag, qualified by valid.
- req_ready_o  out  NREQ  per-requester byte taken this cycle.
- data_o  out  8  byte to the FT2232H data bus.
- wr_o  out  1  FT2232H WR#, active low.
- txe_i  in  1  FT2232H TXE#, active low; the device can accept a byte.
- grant_o  out  NREQ  one-hot current owner; all zero when idle.
- busy_o  out  1  arbiter not in IDLE, or output byte pending.
- tx_count_o  out  32  total bytes accepted by the FT2232H, wrapping.

## Operation
Output stage:
- A one-byte holding register (out_v, data_o) drives the pins; wr_o = ~out_v.
- A byte is accepted on an edge where wr_o==0 and txe_i==0. The accept signal is out_v & ~txe_i.
- Accept clears out_v and increments tx_count_o; the count wraps from 0xFFFFFFFF to 0.
- If txe_i is high, data_o and wr_o hold unchanged until an accepting edge. A byte is never dropped or duplicated.
- The stage can load when load_ok = ~out_v | accept, giving zero bubbles while txe_i stays low.

States:
- IDLE:
  - If any req_valid_i bit is set, select the first valid index searching upward from (last_grant+1) mod NREQ.
  - Register grant_o and clear the burst counter.
  - Go to HDR if FT_TX_HEADER_EN is defined, otherwise go to DATA.
  - Stay in IDLE if no request is valid.
- HDR: when load_ok, load the byte {4'hA, idx[3:0]} into the output stage, then go to DATA.
- DATA:
  - req_ready_o[idx] = load_ok.
  - On the edge where req_valid_i[idx] & req_ready_o[idx], load the requester's byte and increment the burst counter.
  - Leave to IDLE after the transferred byte has req_last_i set, or when the burst counter reaches BURST_MAX.
  - On leaving, record last_grant=idx and clear grant_o.
  - If the requester drops valid, stay in DATA; the owner keeps the port with no timeout.
- req_ready_o is zero for non-granted requesters and outside DATA.
- Truncation at BURST_MAX does not consume the remaining packet. The requester re-arbitrates, and with the header enabled its continuation carries a new header.

## Timing
- Reset values: data_o=0, wr_o=1, grant_o=0, req_ready_o=0, busy_o=0, tx_count_o=0, last_grant=NREQ-1 (so requester 0 wins first), state IDLE.
- Reset mid-burst discards the holding byte and the burst immediately and asynchronously; wr_o goes high.
- Latency with txe_i low, from req_valid_i rising in IDLE:
  - Edge 1: grant.
  - Edge 2: header loaded, wr_o falls.
  - Edge 3: header accepted and first payload byte loaded.
  - Without the header, the first payload byte loads at edge 2.
- Sustained throughput is 1 byte/clock within a burst. There is one IDLE cycle between bursts; wr_o may go high for that cycle.
- txe_i rising on an edge where wr_o==0 means no accept: the byte is held, and req_ready_o drops in the same cycle.
- Simultaneous requests: exactly one is granted per IDLE pass, in rotating order.
- last_i with burst counter == BURST_MAX-1: the burst ends once, with no extra IDLE.

## Configuration
- FT_TX_HEADER_EN defined: the HDR state exists and every grant emits the tag byte 0xA0|idx before its payload. tx_count_o counts tag bytes.
- Not defined: the HDR state is absent and only payload bytes are emitted; IDLE goes directly to DATA.

## Test plan
- Single requester 0 sends 3 bytes 0x11,0x22,0x33 (last on 0x33), txe_i=0:
  - With header: bus accepts A0,11,22,33 on consecutive edges, then grant_o returns to 0 and tx_count_o=4.
  - Without header: bus accepts 11,22,33 and tx_count_o=3.
- All 4 requesters valid continuously with 1-byte packets: grant order is 0,1,2,3,0. Each requester's bytes appear only under its own grant_o bit.
- Throttling: txe_i held high for 5 cycles mid-burst. data_o and wr_o=0 stay stable for those 5 cycles, no requester byte is taken, and the sequence resumes with no loss or duplication.
- BURST_MAX=4 with a requester sending a 10-byte packet, competitor 1 idle: bursts of 4, 4 and 2 bytes. With the header, 3 tags A0 are emitted and tx_count_o=13.
- rst_n_i pulsed low mid-burst: outputs show reset values within the same cycle. After release, requester 0 is granted first again.
- tx_count_o preloaded through force to 0xFFFFFFFE, then 3 bytes accepted: tx_count_o=0x00000001.
